// File: rtl/ppu_spr_eval.sv
// Per-scanline sprite evaluation: scans 64 OAM sprites and copies up to 8 in-range ones into a 32-byte secondary OAM.
// Optional: define SPR_OVF_BUG_EN to reproduce the hardware's diagonal overflow-search bug.
module ppu_spr_eval #(
  parameter logic [7:0] CLR_VAL = 8'hFF
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic [7:0] line_in,
  input  logic       spr_h16_in,
  output logic [7:0] oam_a_out,
  input  logic [7:0] oam_d_in,
  input  logic [4:0] sec_a_in,
  output logic [7:0] sec_d_out,
  output logic       busy_out,
  output logic       done_out,
  output logic [3:0] spr_cnt_out,
  output logic       spr_ovf_out,
  output logic       spr0_out
);

  // state  | meaning
  // IDLE   | waiting for start_in
  // CLEAR  | filling secondary OAM with CLR_VAL, one byte per cycle
  // SCAN   | range-testing the Y byte of sprite n
  // COPY   | copying bytes 1..3 of sprite n into secondary slot cnt
  // OVF    | secondary full; searching for a further in-range sprite
  // DONE   | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SCAN, S_COPY, S_OVF, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  line_q, line_d;
  logic        h16_q, h16_d;
  logic [5:0]  n_q, n_d;
  logic [1:0]  m_q, m_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        spr0_q, spr0_d;
  logic [4:0]  clr_q, clr_d;
  logic [7:0]  sec_q [32];

  logic        sec_we;
  logic [4:0]  sec_wa;
  logic [7:0]  sec_wd;
  logic [8:0]  diff;
  logic [7:0]  height;
  logic        in_range;

  // A borrow in bit 8 means Y lies below the scanline, which never matches.
  assign diff     = {1'b0, line_q} - {1'b0, oam_d_in};
  assign height   = h16_q ? 8'd16 : 8'd8;
  assign in_range = !diff[8] && (diff[7:0] < height);

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    h16_d   = h16_q;
    n_d     = n_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    spr0_d  = spr0_q;
    clr_d   = clr_q;
    sec_we  = 1'b0;
    sec_wa  = 5'd0;
    sec_wd  = 8'd0;

    if (start_in) begin
      state_d = S_CLEAR;
      line_d  = line_in;
      h16_d   = spr_h16_in;
      n_d     = 6'd0;
      m_d     = 2'd0;
      cnt_d   = 4'd0;
      ovf_d   = 1'b0;
      spr0_d  = 1'b0;
      clr_d   = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_CLEAR: begin
          sec_we = 1'b1;
          sec_wa = clr_q;
          sec_wd = CLR_VAL;
          clr_d  = clr_q + 5'd1;
          if (clr_q == 5'd31) begin
            state_d = S_SCAN;
            n_d     = 6'd0;
          end
        end
        S_SCAN: begin
          if (in_range) begin
            sec_we  = 1'b1;
            sec_wa  = {cnt_q[2:0], 2'b00};
            sec_wd  = oam_d_in;
            m_d     = 2'd1;
            state_d = S_COPY;
            if (n_q == 6'd0) spr0_d = 1'b1;
          end else if (n_q == 6'd63) begin
            state_d = S_DONE;
          end else begin
            n_d = n_q + 6'd1;
          end
        end
        S_COPY: begin
          sec_we = 1'b1;
          sec_wa = {cnt_q[2:0], m_q};
          sec_wd = oam_d_in;
          m_d    = m_q + 2'd1;
          if (m_q == 2'd3) begin
            cnt_d = cnt_q + 4'd1;
            if (n_q == 6'd63) begin
              state_d = S_DONE;
            end else begin
              n_d     = n_q + 6'd1;
              state_d = (cnt_q == 4'd7) ? S_OVF : S_SCAN;
            end
          end
        end
        S_OVF: begin
          if (in_range) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else if (n_q == 6'd63) begin
            state_d = S_DONE;
          end else begin
            n_d = n_q + 6'd1;
`ifdef SPR_OVF_BUG_EN
            m_d = m_q + 2'd1;
`else
            m_d = 2'd0;
`endif
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      line_q  <= 8'd0;
      h16_q   <= 1'b0;
      n_q     <= 6'd0;
      m_q     <= 2'd0;
      cnt_q   <= 4'd0;
      ovf_q   <= 1'b0;
      spr0_q  <= 1'b0;
      clr_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      h16_q   <= h16_d;
      n_q     <= n_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      spr0_q  <= spr0_d;
      clr_q   <= clr_d;
    end
  end

  // Secondary OAM is deliberately not reset; CLEAR initialises it every run.
  always_ff @(posedge clk_in) begin
    if (sec_we) sec_q[sec_wa] <= sec_wd;
  end

  assign sec_d_out   = sec_q[sec_a_in];
  assign oam_a_out   = {n_q, (state_q == S_SCAN) ? 2'b00 : m_q};
  assign busy_out    = (state_q != S_IDLE);
  assign done_out    = (state_q == S_DONE);
  assign spr_cnt_out = cnt_q;
  assign spr_ovf_out = ovf_q;
  assign spr0_out    = spr0_q;

endmodule

// File: tb/tb_ppu_spr_eval.sv
// Scoreboard bench for ppu_spr_eval: a sprite-list reference model predicts each run, a done_out monitor checks it.
`timescale 1ns/1ps
module tb_ppu_spr_eval;

  logic       clk = 1'b0;
  logic       rst, start, h16;
  logic [7:0] line, oam_a, oam_d, sec_d;
  logic [4:0] sec_a;
  logic       busy, done, ovf, spr0;
  logic [3:0] cnt;
  logic [7:0] oam [256];

  ppu_spr_eval #(.CLR_VAL(8'hFF)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .line_in(line),
    .spr_h16_in(h16), .oam_a_out(oam_a), .oam_d_in(oam_d),
    .sec_a_in(sec_a), .sec_d_out(sec_d), .busy_out(busy),
    .done_out(done), .spr_cnt_out(cnt), .spr_ovf_out(ovf), .spr0_out(spr0)
  );

  assign oam_d = oam[oam_a];
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int           cnt;
    bit           ovf;
    bit           spr0;
    int           lat;
    logic [255:0] sec;
    int           t0;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: walk the sprite list, keep the first eight that cover the line,
  // then look for a ninth (with the byte-offset drift when the bug is modelled).
  function automatic exp_t model(input int ln, input bit tall);
    exp_t e;
    int h, last, tested, m, y;
    h = tall ? 16 : 8;
    e.cnt = 0; e.ovf = 0; e.spr0 = 0; e.lat = 0; e.t0 = 0;
    for (int i = 0; i < 32; i++) e.sec[i*8 +: 8] = 8'hFF;
    last = -1; tested = 0;
    for (int k = 0; k < 64 && e.cnt < 8; k++) begin
      tested++;
      y = int'(oam[4*k]);
      if (ln - y >= 0 && ln - y < h) begin
        for (int j = 0; j < 4; j++) e.sec[(e.cnt*4 + j)*8 +: 8] = oam[4*k + j];
        if (k == 0) e.spr0 = 1;
        e.cnt++;
        last = k;
      end
    end
    if (e.cnt == 8 && last < 63) begin
      m = 0;
      for (int k = last + 1; k < 64; k++) begin
        tested++;
        y = int'(oam[4*k + m]);
        if (ln - y >= 0 && ln - y < h) begin
          e.ovf = 1;
          break;
        end
`ifdef SPR_OVF_BUG_EN
        m = (m + 1) % 4;
`endif
      end
    end
    e.lat = 32 + tested + 3*e.cnt + 1;
    return e;
  endfunction

  task automatic fill_oam(input logic [7:0] v);
    for (int i = 0; i < 256; i++) oam[i] = v;
  endtask

  task automatic set_spr(input int k, input logic [7:0] y, input logic [7:0] t,
                         input logic [7:0] a, input logic [7:0] x);
    oam[4*k] = y; oam[4*k+1] = t; oam[4*k+2] = a; oam[4*k+3] = x;
  endtask

  task automatic kick(input logic [7:0] ln, input logic tall);
    exp_t e;
    @(negedge clk);
    line = ln; h16 = tall; start = 1'b1;
    e = model(int'(ln), tall);
    e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic abandon_pending();
    if (sb.size() > 0) void'(sb.pop_back());
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
    check("done_within_budget_pending", sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [7:0] ln, input logic tall);
    kick(ln, tall);
    wait_done();
  endtask

  // Monitor: every done_out pulse must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    int bad, first;
    sec_a = 5'd0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("spr_cnt", cnt, e.cnt);
          check("spr_ovf", ovf, e.ovf);
          check("spr0", spr0, e.spr0);
          check("latency", cyc - e.t0, e.lat);
          bad = 0; first = -1;
          for (int i = 0; i < 32; i++) begin
            sec_a = i[4:0];
            #0.1;
            if (sec_d !== e.sec[i*8 +: 8]) begin
              if (first < 0) first = i;
              bad++;
            end
          end
          if (bad != 0)
            $display("note: first bad secondary byte index %0d", first);
          check("sec_bytes_bad", bad, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int dens;
    logic [7:0] ln;
    rst = 1'b1; start = 1'b0; line = 8'd0; h16 = 1'b0;
    fill_oam(8'hFF);
    repeat (3) @(negedge clk);
    check("rst_oam_a", oam_a, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cnt, 0);
    check("rst_ovf", ovf, 0);
    check("rst_spr0", spr0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Empty OAM: 97-cycle run, fully cleared secondary.
    run(8'd100, 1'b0);

    // Sprite 0 at Y=50: bottom row hit, then one line past.
    fill_oam(8'hFF);
    set_spr(0, 8'd50, 8'h12, 8'h03, 8'h40);
    run(8'd57, 1'b0);
    run(8'd58, 1'b0);

    // Sprite 5 at Y=50, line 65: hit only in 8x16 mode.
    fill_oam(8'hFF);
    set_spr(5, 8'd50, 8'h55, 8'h01, 8'h77);
    run(8'd65, 1'b1);
    run(8'd65, 1'b0);

    // Ten sprites on one line: eight copied, overflow search.
    for (int i = 0; i < 256; i++) oam[i] = 8'($urandom);
    for (int k = 0; k < 10; k++) oam[4*k] = 8'd20;
    run(8'd20, 1'b0);

    // Overflow bug probe: sprite 8 misses, sprite 9's tile byte gets tested in bug mode.
    fill_oam(8'hFF);
    for (int k = 0; k < 8; k++) oam[4*k] = 8'd20;
    oam[36] = 8'd20;
    run(8'd20, 1'b0);

    // Last sprite in range, and eighth copy landing on sprite 63.
    fill_oam(8'hFF);
    for (int k = 56; k < 64; k++) set_spr(k, 8'd0, 8'(k), 8'h02, 8'(k+1));
    run(8'd7, 1'b0);

    // Reset mid-SCAN, then a normal run.
    fill_oam(8'hFF);
    kick(8'd100, 1'b0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    abandon_pending();
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_cnt", cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run(8'd100, 1'b0);

    // Restart mid-SCAN: only the second run may report done.
    fill_oam(8'hFF);
    set_spr(3, 8'd190, 8'hA1, 8'hB2, 8'hC3);
    kick(8'd100, 1'b0);
    repeat (45) @(negedge clk);
    abandon_pending();
    kick(8'd195, 1'b0);
    wait_done();

    // Randomised OAM, clustered around the requested line at varying density.
    for (int r = 0; r < 24; r++) begin
      ln = 8'($urandom_range(0, 239));
      dens = $urandom_range(0, 4);
      for (int i = 0; i < 256; i++) oam[i] = 8'($urandom);
      for (int k = 0; k < 64; k++)
        if ($urandom_range(0, 3) < dens)
          oam[4*k] = 8'(int'(ln) - int'($urandom_range(0, 17)));
      run(ln, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
